// File: rtl/adder_unit.sv
// WIDTH-bit adder: zero-latency combinational sum plus a one-cycle registered
// result path carrying sum, carry, signed-overflow and zero flags.
module adder_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             zero_q,
    output logic             valid_q
);

    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    always_comb begin
        s    = {1'b0, a} + {1'b0, b};
        sum  = s[WIDTH-1:0];
        cout = s[WIDTH];
        // Overflow only when both operands share a sign that the result lacks.
        ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        zero = (sum == '0);
    end

    assign y = sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                y_q    <= sum;
                cout_q <= cout;
                ovf_q  <= ovf;
                zero_q <= zero;
            end
        end
    end

endmodule

// File: tb/tb_adder_unit.sv
// Self-checking bench for adder_unit (WIDTH = 8): arithmetic reference model,
// per-cycle compare process and directed literal checks.
module tb_adder_unit;

    localparam int W   = 8;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b, y, y_q;
    logic         in_valid, cout_q, ovf_q, zero_q, valid_q;
    logic         clk_run = 1'b0;
    logic         chk_en  = 1'b0;

    int passed = 0;
    int total  = 0;

    // Model of the registered outputs
    int m_y_q = 0;
    int m_cout_q = 0, m_ovf_q = 0, m_zero_q = 0, m_valid_q = 0;

    adder_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .y        (y),
        .in_valid (in_valid),
        .y_q      (y_q),
        .cout_q   (cout_q),
        .ovf_q    (ovf_q),
        .zero_q   (zero_q),
        .valid_q  (valid_q)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference arithmetic using plain integers and signed interpretation
    function automatic void ref_add(input int ai, input int bi, output int ry,
                                    output int rc, output int rov, output int rz);
        int sum, sa, sb, ss;
        sum = ai + bi;
        ry  = sum % MOD;
        rc  = (sum >= MOD) ? 1 : 0;
        sa  = (ai >= MOD / 2) ? ai - MOD : ai;
        sb  = (bi >= MOD / 2) ? bi - MOD : bi;
        ss  = sa + sb;
        rov = (ss > MOD / 2 - 1 || ss < -(MOD / 2)) ? 1 : 0;
        rz  = (ry == 0) ? 1 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        int ry, rc, rov, rz;
        if (rst) begin
            m_y_q = 0; m_cout_q = 0; m_ovf_q = 0; m_zero_q = 0; m_valid_q = 0;
        end else begin
            m_valid_q = in_valid ? 1 : 0;
            if (in_valid) begin
                ref_add(int'(a), int'(b), ry, rc, rov, rz);
                m_y_q = ry; m_cout_q = rc; m_ovf_q = rov; m_zero_q = rz;
            end
        end
    end

    always @(negedge clk) begin
        int ry, rc, rov, rz;
        if (chk_en && !rst) begin
            ref_add(int'(a), int'(b), ry, rc, rov, rz);
            check("cyc_y",       y,       ry);
            check("cyc_y_q",     y_q,     m_y_q);
            check("cyc_cout_q",  cout_q,  m_cout_q);
            check("cyc_ovf_q",   ovf_q,   m_ovf_q);
            check("cyc_zero_q",  zero_q,  m_zero_q);
            check("cyc_valid_q", valid_q, m_valid_q);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; in_valid = 1'b0;
        #1;
        check("rst_y_q",     y_q,     0);
        check("rst_valid_q", valid_q, 0);
        check("rst_zero_q",  zero_q,  0);

        // Combinational path with no clock running
        a = 8'd5;  b = 8'd3; #10; check("comb_5_3",  y, 8);
        a = 8'd50; b = 8'd5; #10; check("comb_50_5", y, 55);
        in_valid = 1'bx; #1; check("comb_x_valid", y, 55);
        in_valid = 1'b0;

        rst = 1'b0;
        clk_run = 1'b1;
        chk_en  = 1'b1;
        step();

        a = 8'd200; b = 8'd100; in_valid = 1'b1; #1;
        check("comb_200_100", y, 44);
        step();
        check("cap_y_q",     y_q,     44);
        check("cap_cout_q",  cout_q,  1);
        check("cap_ovf_q",   ovf_q,   0);
        check("cap_zero_q",  zero_q,  0);
        check("cap_valid_q", valid_q, 1);
        in_valid = 1'b0;
        step();
        check("hold_valid_q", valid_q, 0);
        check("hold_y_q",     y_q,     44);

        a = 8'd127; b = 8'd1; in_valid = 1'b1;
        step();
        check("maxpos_y_q",    y_q,    128);
        check("maxpos_ovf_q",  ovf_q,  1);
        check("maxpos_cout_q", cout_q, 0);
        a = 8'd128; b = 8'd128;
        step();
        check("minneg_y_q",    y_q,    0);
        check("minneg_ovf_q",  ovf_q,  1);
        check("minneg_cout_q", cout_q, 1);
        check("minneg_zero_q", zero_q, 1);

        a = 8'd255; b = 8'd1;
        step();
        check("ones_y_q",    y_q,    0);
        check("ones_cout_q", cout_q, 1);
        check("ones_zero_q", zero_q, 1);
        in_valid = 1'b0;

        // Asynchronous reset between clock edges
        #1 rst = 1'b1;
        #1;
        check("arst_y_q",     y_q,     0);
        check("arst_cout_q",  cout_q,  0);
        check("arst_ovf_q",   ovf_q,   0);
        check("arst_zero_q",  zero_q,  0);
        check("arst_valid_q", valid_q, 0);
        check("arst_y",       y,       0);
        #1 rst = 1'b0;
        step();
        check("post_rst_valid_q", valid_q, 0);

        // Randomized back-to-back captures
        for (int i = 0; i < 16; i++) begin
            a = W'($urandom_range(0, MOD - 1));
            b = W'($urandom_range(0, MOD - 1));
            in_valid = 1'b1;
            step();
            check("b2b_valid_q", valid_q, 1);
        end
        in_valid = 1'b0;
        step();
        check("end_valid_q", valid_q, 0);
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/adder_unit.md
Name: adder_unit

Overview:
- Parameterised WIDTH-bit unsigned/two's-complement adder used in the CPU datapath (PC increment, address and ALU add paths).
- Provides a zero-latency combinational sum `y` for datapath use.
- Also provides a one-cycle registered result path carrying sum, carry, signed-overflow and zero flags, qualified by a valid strobe, for flag and status logic.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 64.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  asynchronous, active-high reset; clears all registered outputs.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  WIDTH  combinational sum, (a + b) mod 2^WIDTH.
- in_valid  input  1  capture strobe for the registered path.
- y_q  output  WIDTH  registered sum.
- cout_q  output  1  registered unsigned carry-out, bit WIDTH of a + b.
- ovf_q  output  1  registered signed overflow.
- zero_q  output  1  registered flag, high when the captured sum equals 0.
- valid_q  output  1  high for one cycle after a capture.

Behaviour:
- Combinational path:
  - y = (a + b) truncated to WIDTH bits.
  - Zero latency; y depends only on a and b, with no dependence on clk, rst or in_valid.
  - Carry beyond WIDTH is discarded on y.
  - y settles within the same delta/timestep after any change of a or b.
- Internal sum:
  - s = {1'b0,a} + {1'b0,b}, which is WIDTH+1 bits.
  - cout = s[WIDTH].
  - ovf = (a[MSB] == b[MSB]) && (s[MSB] != a[MSB]).
  - zero = (s[WIDTH-1:0] == 0); zero ignores the carry.
- Registered path, on rising clk edge with rst low:
  - If in_valid = 1: y_q <= s[WIDTH-1:0], cout_q <= cout, ovf_q <= ovf, zero_q <= zero, valid_q <= 1.
  - If in_valid = 0: y_q, cout_q, ovf_q and zero_q hold their values; valid_q <= 0.
  - Latency from in_valid sampled high to valid_q high is exactly 1 cycle.
  - Back-to-back in_valid captures every cycle and keeps valid_q high continuously.
- Reset:
  - When rst is asserted (asynchronously, no clock needed): y_q = 0, cout_q = 0, ovf_q = 0, zero_q = 0, valid_q = 0.
  - Reset mid-operation discards any in-flight capture.
  - The first capture is possible on the first rising edge after rst deasserts.
  - The combinational y is unaffected by rst.
- Boundary conditions:
  - All-ones + 1 gives y = 0, cout = 1, zero = 1.
  - Max positive + 1 gives ovf = 1, cout = 0.
  - Min negative + min negative gives ovf = 1, cout = 1, y = 0.
  - WIDTH = 1 degenerates correctly: y = a ^ b, cout = a & b.
- No X propagation from in_valid into y.
- Outputs driven continuously; no tristates.

Test Plan (WIDTH = 8):
- a=5, b=3, wait 10 time units with no clock -> y=8.
- a=50, b=5, wait 10 time units -> y=55.
- a=200, b=100, in_valid=1 for one edge -> y=44 immediately; next cycle y_q=44, cout_q=1, ovf_q=0, zero_q=0, valid_q=1; following cycle with in_valid=0 -> valid_q=0, y_q=44 held.
- a=127, b=1, in_valid=1 -> y_q=128, ovf_q=1, cout_q=0. Then a=128, b=128 -> y_q=0, ovf_q=1, cout_q=1, zero_q=1.
- a=255, b=1 captured, then rst pulsed high between clock edges -> all registered outputs go to 0 immediately; y stays 0 (255+1 mod 256); valid_q stays 0 until the next capture after rst deasserts.
- 16 random (a, b) pairs with in_valid=1 every cycle -> valid_q high continuously; each y_q, cout_q, ovf_q and zero_q matches the reference model one cycle after its inputs were applied.
